// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with an internal IR.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP and raise illegal_instr.
module multi_cycle_control_unit #(
    parameter int unsigned FETCH_LAT = 1,
    parameter int unsigned ALUC_W    = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_code,
    input  logic              d_ready,
    output logic              pc_en,
    output logic              ir_en,
    output logic [ALUC_W-1:0] alu_controls,
    output logic              aluSrcMuxSel,
    output logic [2:0]        RegWdataSel,
    output logic              reg_wr_en,
    output logic              d_wr_en,
    output logic              d_rd_en,
    output logic              branch,
    output logic              JAL,
    output logic              JALR,
    output logic              instr_done,
    output logic              illegal_instr
);

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StTrap    = 3'd5
    } state_e;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;

    localparam logic [3:0] LastCnt = 4'(FETCH_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ir_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7_5;
    logic [3:0] alu4;
    logic       legal, is_store, is_load, is_branch;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign f7_5   = ir_q[30];

    logic unused_ir;
    assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            ir_q    <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ir_en) ir_q <= instr_code;
        end
    end

    // Datapath selects follow the IR in every state; only strobes are state-qualified.
    always_comb begin
        alu4         = 4'd0;
        aluSrcMuxSel = 1'b0;
        RegWdataSel  = 3'd0;
        JAL          = 1'b0;
        JALR         = 1'b0;
        legal        = 1'b1;
        is_store     = 1'b0;
        is_load      = 1'b0;
        is_branch    = 1'b0;
        case (opcode)
            OpR:     alu4 = {f7_5, funct3};
            OpI: begin
                alu4         = {(funct3 == 3'b101) && f7_5, funct3};
                aluSrcMuxSel = 1'b1;
            end
            OpLoad: begin
                aluSrcMuxSel = 1'b1;
                RegWdataSel  = 3'd1;
                is_load      = 1'b1;
            end
            OpStore: begin
                aluSrcMuxSel = 1'b1;
                is_store     = 1'b1;
            end
            OpBr: begin
                alu4      = {1'b0, funct3};
                is_branch = 1'b1;
            end
            OpLui:   RegWdataSel = 3'd2;
            OpAuipc: RegWdataSel = 3'd3;
            OpJal: begin
                RegWdataSel = 3'd4;
                JAL         = 1'b1;
            end
            OpJalr: begin
                RegWdataSel  = 3'd4;
                JALR         = 1'b1;
                aluSrcMuxSel = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign alu_controls = ALUC_W'(alu4);

`ifdef ILLEGAL_TRAP_EN
    logic set_illegal, illegal_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_en     = 1'b0;
        ir_en     = 1'b0;
        reg_wr_en = 1'b0;
        d_wr_en   = 1'b0;
        d_rd_en   = 1'b0;
        branch    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        set_illegal = 1'b0;
`endif
        case (state_q)
            StFetch: begin
                if (cnt_q == LastCnt) begin
                    ir_en   = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = StDecode;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDecode: begin
                if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
                    set_illegal = 1'b1;
                    state_d     = StTrap;
`else
                    pc_en   = 1'b1;
                    state_d = StFetch;
`endif
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                if (is_branch) begin
                    branch  = 1'b1;
                    pc_en   = 1'b1;
                    state_d = StFetch;
                end else if (is_store || is_load) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                d_wr_en = is_store;
                d_rd_en = is_load;
                if (d_ready) begin
                    if (is_store) begin
                        pc_en   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_wr_en = 1'b1;
                pc_en     = 1'b1;
                state_d   = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        instr_done = pc_en;
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) illegal_q <= 1'b0;
        else if (set_illegal) illegal_q <= 1'b1;
    end
    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench: two instances (FETCH_LAT=1/ALUC_W=4 and FETCH_LAT=3/ALUC_W=6) compared
// cycle by cycle against per-instruction expected traces built from the instruction class.
module tb_multi_cycle_control_unit;

    localparam logic [31:0] Nop = 32'h00000013;

    // Strobe vector bit masks: {pc_en, ir_en, reg_wr_en, d_wr_en, d_rd_en, branch, done, illegal}
    localparam logic [7:0] SPc = 8'h80, SIr = 8'h40, SWb = 8'h20, SDw = 8'h10;
    localparam logic [7:0] SDr = 8'h08, SBr = 8'h04, SDn = 8'h02, SIll = 8'h01;

    logic        clk = 1'b0;
    logic [31:0] instr_a [2];
    logic        dready_a [2];
    logic        rst_a [2];
    logic [31:0] model_ir [2];

    logic [1:0] pc_en, ir_en, src, reg_wr_en, d_wr_en, d_rd_en, branch, jal, jalr, done, ill;
    logic [2:0] wsel [2];
    logic [3:0] alu0;
    logic [5:0] alu1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_cycle_control_unit #(.FETCH_LAT(1), .ALUC_W(4), .NOP_INSTR(Nop)) u_dut0 (
        .clk(clk), .reset(rst_a[0]), .instr_code(instr_a[0]), .d_ready(dready_a[0]),
        .pc_en(pc_en[0]), .ir_en(ir_en[0]), .alu_controls(alu0), .aluSrcMuxSel(src[0]),
        .RegWdataSel(wsel[0]), .reg_wr_en(reg_wr_en[0]), .d_wr_en(d_wr_en[0]),
        .d_rd_en(d_rd_en[0]), .branch(branch[0]), .JAL(jal[0]), .JALR(jalr[0]),
        .instr_done(done[0]), .illegal_instr(ill[0])
    );

    multi_cycle_control_unit #(.FETCH_LAT(3), .ALUC_W(6), .NOP_INSTR(Nop)) u_dut1 (
        .clk(clk), .reset(rst_a[1]), .instr_code(instr_a[1]), .d_ready(dready_a[1]),
        .pc_en(pc_en[1]), .ir_en(ir_en[1]), .alu_controls(alu1), .aluSrcMuxSel(src[1]),
        .RegWdataSel(wsel[1]), .reg_wr_en(reg_wr_en[1]), .d_wr_en(d_wr_en[1]),
        .d_rd_en(d_rd_en[1]), .branch(branch[1]), .JAL(jal[1]), .JALR(jalr[1]),
        .instr_done(done[1]), .illegal_instr(ill[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] obs_strobes(input int d);
        return {pc_en[d], ir_en[d], reg_wr_en[d], d_wr_en[d], d_rd_en[d], branch[d], done[d],
                ill[d]};
    endfunction

    // {alu (zero-extended to 8), src, RegWdataSel, JAL, JALR}
    function automatic logic [13:0] obs_sel(input int d);
        logic [7:0] a;
        a = (d == 0) ? {4'd0, alu0} : {2'd0, alu1};
        return {a, src[d], wsel[d], jal[d], jalr[d]};
    endfunction

    function automatic logic [13:0] exp_sel(input logic [31:0] ins);
        logic [7:0] a;
        logic       s;
        logic [2:0] w;
        logic       j, jr;
        logic [2:0] f3;
        a = 8'd0; s = 1'b0; w = 3'd0; j = 1'b0; jr = 1'b0; f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: a = {4'd0, ins[30], f3};
            7'b0010011: begin
                a = (f3 == 3'd5 && ins[30]) ? {4'd1, f3} : {4'd0, f3};
                s = 1'b1;
            end
            7'b0000011: begin s = 1'b1; w = 3'd1; end
            7'b0100011: s = 1'b1;
            7'b1100011: a = {5'd0, f3};
            7'b0110111: w = 3'd2;
            7'b0010111: w = 3'd3;
            7'b1101111: begin w = 3'd4; j = 1'b1; end
            7'b1100111: begin w = 3'd4; jr = 1'b1; s = 1'b1; end
            default: ;
        endcase
        return {a, s, w, j, jr};
    endfunction

    // 0 = ALU/upper/jump (writeback), 1 = store, 2 = load, 3 = branch, 4 = unknown
    function automatic int iclass(input logic [31:0] ins);
        case (ins[6:0])
            7'b0100011: return 1;
            7'b0000011: return 2;
            7'b1100011: return 3;
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: return 0;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] r;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        r = $urandom;
        return {r[31:7], ops[$urandom_range(0, 8)]};
    endfunction

    // One clock cycle: drive, compare at the falling edge, step past the next rising edge.
    task automatic cyc(input int d, input logic [31:0] ic, input logic dr, input logic [7:0] s,
                       input string tag);
        instr_a[d]  = ic;
        dready_a[d] = dr;
        @(negedge clk);
        check_eq($sformatf("d%0d %s strobes", d, tag), 32'(obs_strobes(d)), 32'(s));
        check_eq($sformatf("d%0d %s selects", d, tag), 32'(obs_sel(d)),
                 32'(exp_sel(model_ir[d])));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int d, input logic [31:0] ins, input int w);
        int cls;
        cls = iclass(ins);
        for (int i = 0; i < lat_of(d); i++)
            cyc(d, ins, 1'($urandom), (i == lat_of(d) - 1) ? SIr : 8'h00, "fetch");
        model_ir[d] = ins;
        if (cls == 4) begin
`ifdef ILLEGAL_TRAP_EN
            cyc(d, ins, 1'($urandom), 8'h00, "decode-illegal");
            for (int i = 0; i < 4; i++) cyc(d, ins, 1'($urandom), SIll, "trap");
`else
            cyc(d, ins, 1'($urandom), SPc | SDn, "decode-skip");
`endif
            return;
        end
        cyc(d, ins, 1'($urandom), 8'h00, "decode");
        if (cls == 3) begin
            cyc(d, ins, 1'($urandom), SBr | SPc | SDn, "exec-branch");
            return;
        end
        cyc(d, ins, 1'($urandom), 8'h00, "exec");
        if (cls == 1 || cls == 2) begin
            for (int k = 0; k <= w; k++)
                cyc(d, ins, k == w,
                    (cls == 1) ? (SDw | ((k == w) ? (SPc | SDn) : 8'h00)) : SDr, "mem");
            if (cls == 1) return;
        end
        cyc(d, ins, 1'($urandom), SWb | SPc | SDn, "wb");
    endtask

    task automatic do_reset(input int d);
        rst_a[d]    = 1'b0;
        model_ir[d] = Nop;
        @(negedge clk);
        check_eq($sformatf("d%0d reset strobes", d), 32'(obs_strobes(d)),
                 32'((lat_of(d) == 1) ? SIr : 8'h00));
        check_eq($sformatf("d%0d reset selects", d), 32'(obs_sel(d)), 32'(exp_sel(Nop)));
        @(posedge clk);
        #1;
        rst_a[d] = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b0; instr_a[d] = Nop; dready_a[d] = 1'b0; model_ir[d] = Nop;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset(0);

        // Directed: add, sw with 3 wait cycles, beq
        run_instr(0, 32'h004182B3, 0);
        run_instr(0, 32'h00502423, 3);
        run_instr(0, 32'h00000063, 0);
        for (int i = 0; i < 40; i++) run_instr(0, rand_instr(), $urandom_range(0, 3));
        run_instr(0, 32'hFFFFFFFF, 0);
        do_reset(0);
        run_instr(0, rand_instr(), 0);

        do_reset(1);
        run_instr(1, 32'h40525293, 0);
        for (int i = 0; i < 40; i++) run_instr(1, rand_instr(), $urandom_range(0, 3));

        // Reset while a load is waiting in MEM
        for (int i = 0; i < 3; i++) cyc(1, 32'h00402283, 1'b0, (i == 2) ? SIr : 8'h00, "t6 fetch");
        model_ir[1] = 32'h00402283;
        cyc(1, 32'h00402283, 1'b0, 8'h00, "t6 decode");
        cyc(1, 32'h00402283, 1'b0, 8'h00, "t6 exec");
        cyc(1, 32'h00402283, 1'b0, SDr, "t6 mem");
        #2;
        rst_a[1] = 1'b0;
        #1;
        check_eq("d1 t6 d_rd_en drop", 32'(d_rd_en[1]), 32'd0);
        model_ir[1] = Nop;
        @(negedge clk);
        check_eq("d1 t6 reset strobes", 32'(obs_strobes(1)), 32'd0);
        check_eq("d1 t6 reset ir", 32'(obs_sel(1)), 32'(exp_sel(Nop)));
        @(posedge clk);
        #1;
        rst_a[1] = 1'b1;
        run_instr(1, 32'h004182B3, 0);
        run_instr(1, 32'h00000063, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
